// File: rtl/xilinx_board_status_ctrl.sv
// Board reset/status controller: debounced button reset with synchronous release,
// heartbeat LED, and exit-code capture shown as a repeating LED blink code.
module xilinx_board_status_ctrl #(
  parameter int unsigned CLK_LED_COUNT_LENGTH = 27,
  parameter bit          RST_BTN_ACTIVE_HIGH  = 1'b1,
  parameter int unsigned SYNC_STAGES          = 2,
  parameter int unsigned DEBOUNCE_CYCLES      = 50000,
  parameter int unsigned EXIT_CODE_WIDTH      = 4,
  parameter int unsigned BLINK_CYCLES         = 12500000,
  parameter int unsigned GAP_MULT             = 4
) (
  input  logic                       clk_gen,
  input  logic                       rst_n,
  input  logic                       rst_btn_i,
  output logic                       sys_rst_no,
  output logic                       rst_led_o,
  output logic                       clk_led_o,
  input  logic                       exit_valid_i,
  input  logic [31:0]                exit_value_i,
  output logic                       exit_led_o,
  output logic [EXIT_CODE_WIDTH-1:0] exit_code_o,
  output logic                       exit_seen_o
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmrW = $clog2(GAP_MULT * BLINK_CYCLES + 1);

  localparam logic [SYNC_STAGES-1:0] BtnIdle   = {SYNC_STAGES{~RST_BTN_ACTIVE_HIGH}};
  localparam logic [DbW-1:0]         DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0]        BlinkLoad = TmrW'(BLINK_CYCLES - 1);
  localparam logic [TmrW-1:0]        GapLoad   = TmrW'(GAP_MULT * BLINK_CYCLES - 1);
  localparam logic [31:0]            SatLimit  = 32'((64'd1 << EXIT_CODE_WIDTH) - 64'd1);

  typedef enum logic [2:0] {StIdle, StPass, StOn, StOff, StGap} state_e;

  logic [SYNC_STAGES-1:0]          btn_sync_q;
  logic                            pressed;
  logic                            btn_db_q, btn_db_d;
  logic [DbW-1:0]                  db_cnt_q, db_cnt_d;
  logic [SYNC_STAGES-1:0]          rel_q;
  logic [CLK_LED_COUNT_LENGTH-1:0] hb_q;
  logic                            valid_q, valid_prev_q;
  logic                            exit_edge;
  logic [EXIT_CODE_WIDTH-1:0]      sat_code;
  state_e                          state_q, state_d;
  logic [EXIT_CODE_WIDTH-1:0]      code_q, code_d;
  logic [EXIT_CODE_WIDTH-1:0]      rem_q, rem_d;
  logic [TmrW-1:0]                 timer_q, timer_d;

  assign pressed = btn_sync_q[SYNC_STAGES-1] ^ ~RST_BTN_ACTIVE_HIGH;

  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (pressed != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q   <= BtnIdle;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      rel_q        <= '0;
      hb_q         <= '0;
      valid_q      <= 1'b0;
      valid_prev_q <= 1'b0;
    end else begin
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], rst_btn_i};
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      rel_q        <= {rel_q[SYNC_STAGES-2:0], ~btn_db_q};
      hb_q         <= sys_rst_no ? hb_q + CLK_LED_COUNT_LENGTH'(1) : '0;
      valid_q      <= exit_valid_i;
      valid_prev_q <= valid_q;
    end
  end

  assign sys_rst_no = rel_q[SYNC_STAGES-1];
  assign rst_led_o  = sys_rst_no;
  assign clk_led_o  = hb_q[CLK_LED_COUNT_LENGTH-1];

  // Edge is taken from the registered copy so display starts one cycle after sampling.
  assign exit_edge = valid_q & ~valid_prev_q;
  assign sat_code  = (exit_value_i >= SatLimit) ? '1 : exit_value_i[EXIT_CODE_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    if (!sys_rst_no) begin
      state_d = StIdle;
      code_d  = '0;
      rem_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (exit_edge) begin
            code_d = sat_code;
            if (sat_code == '0) begin
              state_d = StPass;
            end else begin
              state_d = StOn;
              rem_d   = sat_code;
              timer_d = BlinkLoad;
            end
          end
        end
        StPass: ;
        StOn: begin
          if (timer_q == '0) begin
            state_d = StOff;
            timer_d = BlinkLoad;
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        StOff: begin
          if (timer_q == '0) begin
            rem_d = rem_q - EXIT_CODE_WIDTH'(1);
            if (rem_q != EXIT_CODE_WIDTH'(1)) begin
              state_d = StOn;
              timer_d = BlinkLoad;
            end else begin
              state_d = StGap;
              timer_d = GapLoad;
            end
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        StGap: begin
          if (timer_q == '0) begin
            state_d = StOn;
            rem_d   = code_q;
            timer_d = BlinkLoad;
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      rem_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
    end
  end

  assign exit_led_o  = (state_q == StPass) || (state_q == StOn);
  assign exit_seen_o = (state_q != StIdle);
  assign exit_code_o = code_q;

endmodule

// File: tb/tb_xilinx_board_status_ctrl.sv
// Bench for xilinx_board_status_ctrl: reset/heartbeat, debounce on both button polarities,
// table of exit values checked against an expected blink pattern queue, reset mid-sequence.
module tb_xilinx_board_status_ctrl;

  localparam int unsigned CW    = 4;
  localparam int          BLINK = 4;
  localparam int          GAP   = 4;

  logic          clk_gen = 1'b0;
  logic          rst_n;
  logic          rst_btn_i;
  logic          btn_n;
  logic          exit_valid_i;
  logic [31:0]   exit_value_i;
  logic          sys_rst_no, rst_led_o, clk_led_o, exit_led_o, exit_seen_o;
  logic [CW-1:0] exit_code_o;
  logic          sys_rst_no_n, rst_led_o_n, clk_led_o_n, exit_led_o_n, exit_seen_o_n;
  logic [CW-1:0] exit_code_o_n;

  typedef struct {
    logic [31:0]   value;
    logic [CW-1:0] code;
    int            cycles;
  } vec_t;

  vec_t vecs[6];
  bit   exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_gen = ~clk_gen;

  xilinx_board_status_ctrl #(
    .CLK_LED_COUNT_LENGTH(4), .RST_BTN_ACTIVE_HIGH(1'b1), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8), .EXIT_CODE_WIDTH(CW), .BLINK_CYCLES(BLINK), .GAP_MULT(GAP)
  ) dut (
    .clk_gen(clk_gen), .rst_n(rst_n), .rst_btn_i(rst_btn_i), .sys_rst_no(sys_rst_no),
    .rst_led_o(rst_led_o), .clk_led_o(clk_led_o), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .exit_led_o(exit_led_o), .exit_code_o(exit_code_o),
    .exit_seen_o(exit_seen_o)
  );

  xilinx_board_status_ctrl #(
    .CLK_LED_COUNT_LENGTH(4), .RST_BTN_ACTIVE_HIGH(1'b0), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8), .EXIT_CODE_WIDTH(CW), .BLINK_CYCLES(BLINK), .GAP_MULT(GAP)
  ) dut_n (
    .clk_gen(clk_gen), .rst_n(rst_n), .rst_btn_i(btn_n), .sys_rst_no(sys_rst_no_n),
    .rst_led_o(rst_led_o_n), .clk_led_o(clk_led_o_n), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .exit_led_o(exit_led_o_n), .exit_code_o(exit_code_o_n),
    .exit_seen_o(exit_seen_o_n)
  );

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_code(input string name, input logic [CW-1:0] got,
                            input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_gen);
  endtask

  task automatic press(input bit p);
    rst_btn_i = p;
    btn_n     = ~p;
  endtask

  // Expected LED at cycle t after the first ON cycle, from the blink-code definition.
  function automatic bit exp_led(input int code, input int t);
    int on_len;
    int p;
    if (code == 0) return 1'b1;
    on_len = 2 * code * BLINK;
    p = t % (on_len + GAP * BLINK);
    if (p < on_len) return (p % (2 * BLINK)) < BLINK;
    return 1'b0;
  endfunction

  // Press: reset must assert exactly 2 + 8 + 2 edges after the button edge.
  task automatic press_and_check();
    press(1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 11) begin
        check_bit("press_early", sys_rst_no, 1'b1);
        check_bit("press_early_n", sys_rst_no_n, 1'b1);
      end
      if (i == 12) begin
        check_bit("press_lat", sys_rst_no, 1'b0);
        check_bit("press_lat_n", sys_rst_no_n, 1'b0);
        check_bit("press_rst_led", rst_led_o, 1'b0);
      end
    end
  endtask

  task automatic release_and_check();
    press(1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 11) begin
        check_bit("release_early", sys_rst_no, 1'b0);
        check_bit("release_early_n", sys_rst_no_n, 1'b0);
      end
      if (i == 12) begin
        check_bit("release_lat", sys_rst_no, 1'b1);
        check_bit("release_lat_n", sys_rst_no_n, 1'b1);
        check_bit("release_rst_led", rst_led_o, 1'b1);
      end
    end
  endtask

  task automatic btn_cycle();
    press_and_check();
    repeat (8) tick();
    release_and_check();
  endtask

  task automatic glitch(input int len);
    bit ok;
    ok = 1'b1;
    press(1'b1);
    repeat (len) tick();
    press(1'b0);
    repeat (24) begin
      tick();
      if (!sys_rst_no || !sys_rst_no_n) ok = 1'b0;
    end
    check_bit($sformatf("glitch_%0d_stays_high", len), ok, 1'b1);
  endtask

  task automatic run_exit(input logic [31:0] value, input logic [CW-1:0] code,
                          input int cycles);
    bit e;
    exit_value_i = value;
    exit_valid_i = 1'b1;
    tick();
    check_bit("exit_seen_before_latency", exit_seen_o, 1'b0);
    for (int t = 0; t < cycles; t++) exp_q.push_back(exp_led(int'(code), t));
    for (int t = 0; t < cycles; t++) begin
      tick();
      e = exp_q.pop_front();
      check_bit($sformatf("exit_led_v%0h_t%0d", value, t), exit_led_o, e);
      if (t == 0) begin
        check_bit("exit_seen", exit_seen_o, 1'b1);
        check_code($sformatf("exit_code_v%0h", value), exit_code_o, code);
      end
    end
    exit_valid_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic hb_e;
    bit   ok;

    vecs[0] = '{32'h0,  4'h0, 20};
    vecs[1] = '{32'h3,  4'h3, 84};
    vecs[2] = '{32'h20, 4'hF, 140};
    vecs[3] = '{32'hE,  4'hE, 132};
    vecs[4] = '{32'h10, 4'hF, 40};
    vecs[5] = '{32'hF,  4'hF, 20};

    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    press(1'b0);
    repeat (3) tick();
    check_bit("rst_sys_rst_no", sys_rst_no, 1'b0);
    check_bit("rst_rst_led", rst_led_o, 1'b0);
    check_bit("rst_clk_led", clk_led_o, 1'b0);
    check_bit("rst_exit_led", exit_led_o, 1'b0);
    check_code("rst_exit_code", exit_code_o, '0);
    check_bit("rst_exit_seen", exit_seen_o, 1'b0);
    check_bit("rst_sys_rst_no_n", sys_rst_no_n, 1'b0);

    // Release lands after 2 edges; heartbeat counter starts counting from edge 3.
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      hb_e = (i >= 2) ? (((i - 2) % 16) >= 8) : 1'b0;
      check_bit($sformatf("release_sys_%0d", i), sys_rst_no, i >= 2);
      check_bit($sformatf("heartbeat_%0d", i), clk_led_o, hb_e);
    end
    check_bit("release_sys_n", sys_rst_no_n, 1'b1);

    glitch(5);
    glitch(7);
    btn_cycle();

    for (int v = 0; v < 6; v++) begin
      run_exit(vecs[v].value, vecs[v].code, vecs[v].cycles);
      if (vecs[v].code == '0) begin
        exit_value_i = 32'h5;
        exit_valid_i = 1'b1;
        repeat (6) tick();
        check_bit("pass_second_edge_led", exit_led_o, 1'b1);
        check_code("pass_second_edge_code", exit_code_o, '0);
        exit_valid_i = 1'b0;
        tick();
        tick();
      end
      btn_cycle();
      check_bit("idle_after_reset_seen", exit_seen_o, 1'b0);
      check_code("idle_after_reset_code", exit_code_o, '0);
    end

    // Reset during the second ON phase, with an exit edge arriving while in reset.
    exit_value_i = 32'h3;
    exit_valid_i = 1'b1;
    tick();
    repeat (10) tick();
    check_bit("midop_second_on", exit_led_o, 1'b1);
    press_and_check();
    tick();
    check_bit("midop_led_cleared", exit_led_o, 1'b0);
    check_code("midop_code_cleared", exit_code_o, '0);
    check_bit("midop_seen_cleared", exit_seen_o, 1'b0);
    exit_valid_i = 1'b0;
    tick();
    tick();
    exit_value_i = 32'h5;
    exit_valid_i = 1'b1;
    repeat (5) tick();
    release_and_check();
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (exit_seen_o) ok = 1'b0;
    end
    check_bit("edge_in_reset_dropped", ok, 1'b1);
    exit_valid_i = 1'b0;
    tick();
    tick();
    run_exit(32'h1, 4'h1, 52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xilinx_board_status_ctrl.md
# xilinx_board_status_ctrl

Board-level reset and status controller for the FPGA top wrappers. It debounces and synchronises the raw board reset button into a clean system reset (asynchronous assert, synchronous deassert). It drives the reset and heartbeat LEDs and latches the program exit status. A failing exit code is shown on an LED as a repeating blink code. The block sits between the clock wizard output and the SoC top-level instance.

## Interface
Parameters:
- CLK_LED_COUNT_LENGTH, 27: heartbeat counter width; clk_led_o is its MSB.
- RST_BTN_ACTIVE_HIGH, 1: polarity of rst_btn_i (1 = pressed when high).
- SYNC_STAGES, 2 (≥2): depth of both the button synchroniser and the reset-release synchroniser.
- DEBOUNCE_CYCLES, 50000 (≥1): consecutive stable cycles required to accept a button change.
- EXIT_CODE_WIDTH, 4 (1..8): displayed exit-code width.
- BLINK_CYCLES, 12500000 (≥1): duration of one blink on-phase; the off-phase is the same length.
- GAP_MULT, 4 (≥1): inter-sequence gap, in units of BLINK_CYCLES.

Ports:
- clk_gen  in  1  system clock from the clock wizard.
- rst_n  in  1  asynchronous, active-low reset (power-on/locked).
- rst_btn_i  in  1  raw board reset button, asynchronous to clk_gen.
- sys_rst_no  out  1  system reset to the SoC, active-low.
- rst_led_o  out  1  equals sys_rst_no.
- clk_led_o  out  1  heartbeat LED.
- exit_valid_i  in  1  SoC exit-valid, synchronous to clk_gen.
- exit_value_i  in  32  SoC exit value.
- exit_led_o  out  1  exit status LED.
- exit_code_o  out  EXIT_CODE_WIDTH  latched, saturated exit code.
- exit_seen_o  out  1  high once an exit has been latched.

## Operation
- **Button path**
  - rst_btn_i passes through a SYNC_STAGES flop chain. The chain resets to the inactive level.
  - The synchronised value is normalised to `pressed` (XOR with !RST_BTN_ACTIVE_HIGH).
- **Debounce**
  - Stable state btn_db resets to 0.
  - When pressed != btn_db, a counter increments. When pressed == btn_db, the counter clears to 0.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, btn_db toggles and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- **Reset release**
  - A SYNC_STAGES shift register shifts in !btn_db each cycle. rst_n low clears it asynchronously to 0.
  - sys_rst_no is the last stage. Assertion is asynchronous on rst_n and synchronous on the button.
- **Heartbeat**
  - A CLK_LED_COUNT_LENGTH counter increments every cycle and wraps at all-ones.
  - It clears asynchronously on rst_n and synchronously while sys_rst_no == 0.
- **Exit capture**
  - exit_valid_i is registered (reset 0) for rising-edge detection.
  - A rising edge in IDLE latches the code. If exit_value_i ≥ 2^EXIT_CODE_WIDTH−1, the code saturates to all-ones; otherwise it is exit_value_i[EXIT_CODE_WIDTH-1:0].
  - Edges outside IDLE are ignored.
- **FSM states:** IDLE, PASS, ON, OFF, GAP.
  - IDLE: on an edge, go to PASS if the code is 0, else to ON with remaining=code and timer=BLINK_CYCLES−1.
  - PASS: terminal.
  - ON: when timer hits 0, go to OFF with timer reloaded to BLINK_CYCLES−1.
  - OFF: when timer hits 0, decrement remaining. If the result is ≠0, go to ON; else go to GAP with timer=GAP_MULT·BLINK_CYCLES−1.
  - GAP: when timer hits 0, go to ON with remaining=code.
  - The timer is $clog2(GAP_MULT·BLINK_CYCLES+1) bits wide and counts down.
- **FSM outputs** (decoded from registered state)
  - exit_led_o = 1 in PASS and ON, 0 otherwise.
  - exit_seen_o = (state != IDLE).
  - exit_code_o holds the latched code; it is 0 in IDLE.
- **Reset behaviour:** sys_rst_no == 0 synchronously forces the FSM to IDLE and clears the code. This handles a button press mid-sequence.

## Timing
- **Reset values:** sys_rst_no=0, rst_led_o=0, clk_led_o=0, exit_led_o=0, exit_code_o=0, exit_seen_o=0.
- **Reset release:** with the button released, sys_rst_no rises on the SYNC_STAGES-th rising clk_gen edge after rst_n deasserts.
- **Button press latency:** an accepted press asserts sys_rst_no low SYNC_STAGES + DEBOUNCE_CYCLES + SYNC_STAGES cycles after the edge on rst_btn_i (±1 for input sampling). Release has the same latency.
- **Glitch rejection:** a pressed pulse shorter than DEBOUNCE_CYCLES synchronised cycles has no effect.
- **Exit display latency:** if exit_valid_i is first sampled high at edge k, the state changes and exit_led_o updates from the cycle after edge k+1.
- **Blink timing:** each ON and OFF phase lasts exactly BLINK_CYCLES cycles; GAP lasts GAP_MULT·BLINK_CYCLES cycles.
- **Blink period:** 2·code·BLINK_CYCLES + GAP_MULT·BLINK_CYCLES.
- **Simultaneous events:** an exit_valid_i edge coinciding with sys_rst_no==0 is dropped; reset wins.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, BLINK_CYCLES=4, GAP_MULT=4, EXIT_CODE_WIDTH=4, CLK_LED_COUNT_LENGTH=4.
- **Reset release and heartbeat:** release rst_n with the button idle -> sys_rst_no=1 after 2 edges; clk_led_o toggles every 8 cycles.
- **Debounce:** press for 5 cycles -> sys_rst_no stays 1. Press for 20 cycles -> sys_rst_no low within 2+8+2 cycles, and high again 12 cycles after release. Repeat with RST_BTN_ACTIVE_HIGH=0 using inverted stimulus.
- **Pass code:** exit_value_i=0 with an exit_valid_i rise -> exit_led_o solid 1, exit_seen_o=1, exit_code_o=0; a second edge is ignored.
- **Blink code 3:** exit_value_i=3 -> exactly 3 pulses of 4 cycles high / 4 low, then 16 cycles low, repeating with a period of 40 cycles.
- **Saturation:** exit_value_i=0x20 -> exit_code_o=0xF and 15 pulses per sequence. exit_value_i=0xE -> code 0xE.
- **Reset mid-operation:** press the button during the second ON phase -> FSM returns to IDLE, exit_led_o=0, exit_code_o=0. After release, a new exit_valid_i edge with value 1 produces 1 pulse per 24-cycle period.
